// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//
// Scan controller for a 4-digit multiplexed seven-segment display. Each
// digit owns one slot of REFRESH_DIV cycles. The first BLANK_CYCLES cycles
// of a slot keep every digit dark, which gives break-before-make and stops
// ghosting. The remaining cycles show the digit. New values are
// double-buffered in a shadow register. They are copied into the display
// register only when digit 0 is about to be shown, so a frame never mixes
// old and new digits.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   en         scan enable; 0 holds the display dark
//   load       one-cycle strobe that captures bcd_in/dp_in
//   bcd_in     four BCD nibbles, [3:0] is digit 0 (rightmost)
//   dp_in      decimal-point bit per digit
//   lz_en      enables leading-zero blanking
//   cntrl      digit index for the digit decoder
//   bcd_out    nibble of the current digit for the segment encoder
//   dp_out     decimal point of the current digit
//   blank      1 forces all digit enables inactive
//   ack        one-cycle pulse: the loaded value is now being displayed
//   frame_done one-cycle pulse at each 3->0 digit wrap
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [1:0]  cntrl,
  output logic [3:0]  bcd_out,
  output logic        dp_out,
  output logic        blank,
  output logic        ack,
  output logic        frame_done
);

  localparam logic [19:0] BLANK_LAST = 20'(BLANK_CYCLES - 1);
  localparam logic [19:0] SLOT_LAST  = 20'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] shadow_bcd_q, shadow_bcd_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic        pending_q, pending_d;
  logic [15:0] disp_bcd_q, disp_bcd_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  logic [1:0]  cntrl_q, cntrl_d;
  logic [3:0]  bcd_out_q, bcd_out_d;
  logic        dp_out_q, dp_out_d;
  logic        blank_q, blank_d;
  logic        ack_q, ack_d;
  logic        frame_done_q, frame_done_d;
  logic        boundary;

  // Select the nibble for a given digit index.
  function automatic logic [3:0] pick_nibble(input logic [15:0] v, input logic [1:0] i);
    logic [3:0] n;
    case (i)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      default: n = v[15:12];
    endcase
    return n;
  endfunction

  // A digit is a leading zero when it and every more-significant digit are
  // zero. Digit 0 always stays visible so a value of zero still shows "0".
  function automatic logic lz_blanked(input logic [15:0] v, input logic [1:0] i);
    logic b;
    case (i)
      2'd3:    b = (v[15:12] == 4'h0);
      2'd2:    b = (v[15:8] == 8'h00);
      2'd1:    b = (v[15:4] == 12'h000);
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // Next-state logic. It first decides where the scan goes next: slot
  // counter, digit index and state. From that it knows whether this edge is
  // a frame boundary, meaning entry into digit-0 BLANK. At a boundary the
  // display register may take a new value. That value comes straight from
  // bcd_in when a load coincides with the boundary, otherwise from the
  // shadow. Every output is then computed from the *next* index and display
  // value, so the registered outputs already show the new digit in the
  // first BLANK cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    disp_bcd_d   = disp_bcd_q;
    disp_dp_d    = disp_dp_q;
    ack_d        = 1'b0;
    frame_done_d = 1'b0;
    boundary     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 20'd0;
        idx_d = 2'd0;
        if (en) begin
          state_d  = ST_BLANK;
          boundary = 1'b1;
        end
      end
      ST_BLANK: begin
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = 20'd0;
          idx_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 20'd1;
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
          end
        end
      end
      ST_SHOW: begin
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = 20'd0;
          idx_d   = 2'd0;
        end else if (cnt_q == SLOT_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = 20'd0;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            boundary     = 1'b1;
            frame_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 20'd0;
        idx_d   = 2'd0;
      end
    endcase

    // While idle nothing is on screen, so a load may go straight to the
    // display register without tearing a frame.
    if (boundary || state_q == ST_IDLE) begin
      if (load) begin
        disp_bcd_d = bcd_in;
        disp_dp_d  = dp_in;
        pending_d  = 1'b0;
        ack_d      = 1'b1;
      end else if (boundary && pending_q) begin
        disp_bcd_d = shadow_bcd_q;
        disp_dp_d  = shadow_dp_q;
        pending_d  = 1'b0;
        ack_d      = 1'b1;
      end
    end else if (load) begin
      shadow_bcd_d = bcd_in;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end

    cntrl_d   = idx_d;
    bcd_out_d = pick_nibble(disp_bcd_d, idx_d);
    dp_out_d  = disp_dp_d[idx_d];
    blank_d   = (state_d == ST_SHOW) ? (lz_en && lz_blanked(disp_bcd_d, idx_d)) : 1'b1;
  end

  // State and output registers. Reset leaves the display dark, with blank
  // high and both the display and shadow buffers cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 20'd0;
      idx_q        <= 2'd0;
      shadow_bcd_q <= 16'h0000;
      shadow_dp_q  <= 4'h0;
      pending_q    <= 1'b0;
      disp_bcd_q   <= 16'h0000;
      disp_dp_q    <= 4'h0;
      cntrl_q      <= 2'd0;
      bcd_out_q    <= 4'h0;
      dp_out_q     <= 1'b0;
      blank_q      <= 1'b1;
      ack_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_dp_q    <= disp_dp_d;
      cntrl_q      <= cntrl_d;
      bcd_out_q    <= bcd_out_d;
      dp_out_q     <= dp_out_d;
      blank_q      <= blank_d;
      ack_q        <= ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign cntrl      = cntrl_q;
  assign bcd_out    = bcd_out_q;
  assign dp_out     = dp_out_q;
  assign blank      = blank_q;
  assign ack        = ack_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl
//
// Bench for display_scan_ctrl with a short slot of 8 cycles and 2 blanking
// cycles. Each scenario pushes the expected per-cycle output vector
// {cntrl, bcd_out, dp_out, blank, ack, frame_done} into a queue while it
// drives stimulus. It then pops one entry per clock and compares it with
// what the DUT shows.
module tb_display_scan_ctrl;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam logic [9:0] RESET_V = {2'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [1:0]  cntrl;
  logic [3:0]  bcd_out;
  logic        dp_out;
  logic        blank;
  logic        ack;
  logic        frame_done;

  logic [9:0]  obs;
  logic [9:0]  exp_v;
  logic [9:0]  exp_q[$];
  int          checks;
  int          failures;

  display_scan_ctrl #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .bcd_in    (bcd_in),
    .dp_in     (dp_in),
    .lz_en     (lz_en),
    .cntrl     (cntrl),
    .bcd_out   (bcd_out),
    .dp_out    (dp_out),
    .blank     (blank),
    .ack       (ack),
    .frame_done(frame_done)
  );

  assign obs = {cntrl, bcd_out, dp_out, blank, ack, frame_done};

  // Free-running clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge, where outputs are settled
  // and new inputs can be driven for the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for one digit slot, built from the behaviour of the
  // display. The digit has BC dark cycles, then shows for the rest of the
  // slot. It stays dark in the show part only if leading-zero blanking
  // applies. ack and frame_done sit on the first cycle only.
  task automatic push_slot(input logic [1:0] idx, input logic [15:0] val, input logic [3:0] dp,
                           input logic lz, input logic first_ack, input logic first_fd,
                           input int cycles);
    logic [15:0] shifted;
    logic [3:0]  nib;
    logic        lzb;
    shifted = val >> (4 * idx);
    nib     = shifted[3:0];
    lzb     = lz && (idx != 2'd0) && (shifted == 16'h0000);
    for (int c = 0; c < cycles; c++) begin
      exp_q.push_back({idx, nib, dp[idx], (c < BC) ? 1'b1 : lzb,
                       (c == 0) && first_ack, (c == 0) && first_fd});
    end
  endtask

  task automatic push_frame(input logic [15:0] val, input logic [3:0] dp, input logic lz,
                            input logic first_ack, input logic first_fd);
    for (int k = 0; k < 4; k++) begin
      push_slot(2'(k), val, dp, lz, (k == 0) && first_ack, (k == 0) && first_fd, RD);
    end
  endtask

  // Reset values, and a load while reset is held must be ignored.
  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; bcd_in = 16'h0000; dp_in = 4'h0; lz_en = 1'b0;
    tick();
    checks++;
    if (obs !== RESET_V) begin
      failures++;
      $display("[TB] FAIL reset_state got=%b expected=%b", obs, RESET_V);
    end
    load = 1'b1; bcd_in = 16'hFFFF; dp_in = 4'hF;
    tick();
    checks++;
    if (obs !== RESET_V) begin
      failures++;
      $display("[TB] FAIL load_in_reset got=%b expected=%b", obs, RESET_V);
    end
    rst = 1'b0; load = 1'b0;
    tick();
    checks++;
    if (obs !== RESET_V) begin
      failures++;
      $display("[TB] FAIL idle_after_reset got=%b expected=%b", obs, RESET_V);
    end
  endtask

  // Load 1234 while idle, then scan two full frames.
  task automatic test_basic_scan();
    int n;
    load = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0101;
    exp_q.push_back({2'd0, 4'h4, 1'b1, 1'b1, 1'b1, 1'b0});
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("[TB] FAIL idle_load_ack got=%b expected=%b", obs, exp_v);
    end
    load = 1'b0; en = 1'b1;
    push_frame(16'h1234, 4'b0101, 1'b0, 1'b0, 1'b0);
    push_frame(16'h1234, 4'b0101, 1'b0, 1'b0, 1'b1);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL basic_scan cycle=%0d got=%b expected=%b", i, obs, exp_v);
      end
    end
  endtask

  // Two loads inside one frame: only the last is shown, with a single ack.
  task automatic test_double_load();
    int n;
    push_frame(16'h1234, 4'b0101, 1'b0, 1'b0, 1'b1);
    push_frame(16'h9ABC, 4'b1000, 1'b0, 1'b1, 1'b1);
    push_frame(16'h9ABC, 4'b1000, 1'b0, 1'b0, 1'b1);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL double_load cycle=%0d got=%b expected=%b", i, obs, exp_v);
      end
      if (i == 11) begin load = 1'b1; bcd_in = 16'h5678; dp_in = 4'b0010; end
      if (i == 12) load = 1'b0;
      if (i == 25) begin load = 1'b1; bcd_in = 16'h9ABC; dp_in = 4'b1000; end
      if (i == 26) load = 1'b0;
    end
  endtask

  // Leading-zero blanking with 0050 and then 0000.
  task automatic test_leading_zero();
    int n;
    push_frame(16'h9ABC, 4'b1000, 1'b1, 1'b0, 1'b1);
    push_frame(16'h0050, 4'b0000, 1'b1, 1'b1, 1'b1);
    push_frame(16'h0000, 4'b0000, 1'b1, 1'b1, 1'b1);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL leading_zero cycle=%0d got=%b expected=%b", i, obs, exp_v);
      end
      if (i == 5)  begin load = 1'b1; lz_en = 1'b1; bcd_in = 16'h0050; dp_in = 4'b0000; end
      if (i == 6)  load = 1'b0;
      if (i == 37) begin load = 1'b1; bcd_in = 16'h0000; dp_in = 4'b0000; end
      if (i == 38) load = 1'b0;
      if (i == 69) begin load = 1'b1; bcd_in = 16'h8765; dp_in = 4'b1010; end
      if (i == 70) load = 1'b0;
    end
  endtask

  // Drop en in the SHOW part of digit 2 while a load is pending. Then
  // re-enable: the pending value appears with ack but without frame_done.
  task automatic test_enable_drop();
    int n;
    lz_en = 1'b0;
    push_slot(2'd0, 16'h8765, 4'b1010, 1'b0, 1'b1, 1'b1, RD);
    push_slot(2'd1, 16'h8765, 4'b1010, 1'b0, 1'b0, 1'b0, RD);
    push_slot(2'd2, 16'h8765, 4'b1010, 1'b0, 1'b0, 1'b0, BC + 2);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL enable_drop cycle=%0d got=%b expected=%b", i, obs, exp_v);
      end
      if (i == 10)    begin load = 1'b1; bcd_in = 16'h4321; dp_in = 4'b0001; end
      if (i == 11)    load = 1'b0;
      if (i == n - 1) en = 1'b0;
    end
    for (int k = 0; k < 3; k++) exp_q.push_back({2'd0, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0});
    push_frame(16'h4321, 4'b0001, 1'b0, 1'b1, 1'b0);
    push_frame(16'h4321, 4'b0001, 1'b0, 1'b0, 1'b1);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL enable_restart cycle=%0d got=%b expected=%b", i, obs, exp_v);
      end
      if (i == 2) en = 1'b1;
    end
  endtask

  // Reset in the middle of a SHOW with a load pending. Outputs must clear
  // at once. After release the display reads 0 and no ack appears.
  task automatic test_reset_mid_frame();
    int n;
    push_slot(2'd0, 16'h4321, 4'b0001, 1'b0, 1'b0, 1'b1, RD);
    push_slot(2'd1, 16'h4321, 4'b0001, 1'b0, 1'b0, 1'b0, BC + 3);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL pre_reset cycle=%0d got=%b expected=%b", i, obs, exp_v);
      end
      if (i == 3) begin load = 1'b1; bcd_in = 16'hAAAA; dp_in = 4'hF; end
      if (i == 4) load = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== RESET_V) begin
      failures++;
      $display("[TB] FAIL async_reset got=%b expected=%b", obs, RESET_V);
    end
    tick();
    rst = 1'b0;
    push_frame(16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL post_reset cycle=%0d got=%b expected=%b", i, obs, exp_v);
      end
    end
  endtask

  // A load on the exact wrap edge goes straight to the display: ack and
  // frame_done coincide, and the following frame carries no second ack.
  task automatic test_load_on_wrap();
    int n;
    push_frame(16'h0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    push_frame(16'h2468, 4'b0001, 1'b0, 1'b1, 1'b1);
    push_frame(16'h2468, 4'b0001, 1'b0, 1'b0, 1'b1);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("[TB] FAIL load_on_wrap cycle=%0d got=%b expected=%b", i, obs, exp_v);
      end
      if (i == 31) begin load = 1'b1; bcd_in = 16'h2468; dp_in = 4'b0001; end
      if (i == 32) load = 1'b0;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_scan();
    test_double_load();
    test_leading_zero();
    test_enable_drop();
    test_reset_mid_frame();
    test_load_on_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
